i2c_ina219_target: RTL
======================

I2C_INA219_TARGET -- requirements
Module: i2c_ina219_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h40, 7-bit I2C target address.
REQ-002 Parameter CONFIG_RST, default 16'h399F, reset value of register 0 (config).
REQ-003 clk  input  1  50 MHz system clock; sole clock of the block.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 scl  input  1  I2C clock from the bus master; never driven.
REQ-006 sda  inout  1  I2C data, open-drain: driven 0 or high-Z only, never driven 1.
REQ-007 shunt_v  input  16  value returned for register 1.
REQ-008 bus_v  input  16  value returned for register 2.
REQ-009 config_out  output  16  current contents of register 0.
REQ-010 busy  output  1  high from a START addressed to DEV_ADDR until STOP.
REQ-011 xfer_done  output  1  one-clk pulse on the STOP that ends an addressed transaction.

Function
REQ-012 scl and sda SHALL each pass through a 2-flop synchronizer; all edge and condition detection SHALL use the synchronized values.
REQ-013 START (synchronized SDA falls while SCL high) SHALL force state ADDR and bit count 7 from any state, including mid-byte (repeated START).
REQ-014 STOP (synchronized SDA rises while SCL high) SHALL force state IDLE and release sda from any state.
REQ-015 Data SHALL be sampled on synchronized SCL rising edges, MSB first; sda drive changes SHALL occur only on synchronized SCL falling edges.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_MSB, WR_MSB_ACK, WR_LSB, WR_LSB_ACK, RD_MSB, RD_LSB, RD_MACK, WAIT_STOP.
REQ-017 ADDR: after 8 bits, address match -> ADDR_ACK (drive 0 for one SCL period); mismatch -> WAIT_STOP with sda released and busy low.
REQ-018 Address R/W=0 -> PTR; received pointer byte [1:0] SHALL be stored as pointer, ACKed, then -> WR_MSB.
REQ-019 WR_MSB/WR_LSB: both bytes ACKed; on WR_LSB completion with pointer 0, config SHALL update atomically with {MSB,LSB}; writes to other pointers ACKed and discarded; after WR_LSB_ACK -> WAIT_STOP.
REQ-020 Address R/W=1: on the ADDR_ACK rising edge a 16-bit snapshot SHALL be latched (ptr 0 config, 1 shunt_v, 2 bus_v, 3 16'h0000) and shifted out RD_MSB then RD_LSB.
REQ-021 Read bits: data 0 -> drive low; data 1 -> high-Z.
REQ-022 RD_MACK after MSB: master ACK (0) -> RD_LSB; NACK -> WAIT_STOP, sda released.
REQ-023 RD_MACK after LSB: either response -> WAIT_STOP; no wrap, no auto-increment.
REQ-024 Pointer SHALL persist across transactions; a read without a preceding pointer write uses the last pointer.
REQ-025 Timing: sda settles within 4 clk of the SCL falling edge at the pins; SCL high/low phases of at least 8 clk SHALL be supported (100 kHz and 400 kHz).
REQ-026 START and STOP seen in the same clk cannot occur; a STOP seen while in IDLE SHALL produce no xfer_done.

Reset
REQ-027 On reset low: state IDLE, sda released, pointer 0, config_out CONFIG_RST, busy 0, xfer_done 0, snapshot 0, synchronizers 1.
REQ-028 Reset asserted mid-transaction SHALL release sda immediately (asynchronously); after release the block ignores the bus until the next START.

Structure
REQ-029 State encoding, register-index constants and the 2'b pointer widths SHALL live in shared package i2c_pkg, also usable by the bus master.
REQ-030 The synchronizer plus START/STOP/edge detector SHALL be sub-module i2c_bus_monitor.

Verification
REQ-031 After reset, master reads at 0x40 -> ACK, bytes 0x39,0x9F, xfer_done pulse at STOP.
REQ-032 Write ptr 0x01, repeated START, read with shunt_v=16'hA55A -> 0xA5,0x5A; busy high throughout.
REQ-033 Write 0x00,0x12,0x34, STOP -> config_out=16'h1234 and a later read returns 0x12,0x34.
REQ-034 Address 0x41 -> sda never driven low, busy stays 0, no xfer_done.
REQ-035 Read with master NACK after MSB -> sda released during LSB slot, STOP returns IDLE.
REQ-036 reset pulled low during RD_MSB while driving 0 -> sda high-Z same cycle; config_out back to 16'h399F.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, register pointer type and register map.
// Usable by both the INA219-style target and any bus master model.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_MSB,
    WR_MSB_ACK,
    WR_LSB,
    WR_LSB_ACK,
    RD_MSB,
    RD_LSB,
    RD_MACK,
    WAIT_STOP
  } i2c_state_e;

  localparam int PTR_W = 2;
  typedef logic [PTR_W-1:0] i2c_ptr_t;

  localparam i2c_ptr_t REG_CONFIG = 2'd0;
  localparam i2c_ptr_t REG_SHUNT  = 2'd1;
  localparam i2c_ptr_t REG_BUS    = 2'd2;
  localparam i2c_ptr_t REG_NONE   = 2'd3;

  function automatic logic [15:0] regSelect(input i2c_ptr_t ptr, input logic [15:0] cfg,
                                            input logic [15:0] shunt, input logic [15:0] bus);
    logic [15:0] value;
    case (ptr)
      REG_CONFIG: value = cfg;
      REG_SHUNT:  value = shunt;
      REG_BUS:    value = bus;
      default:    value = 16'h0000;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes raw scl/sda into the clk domain and flags SCL edges and START/STOP conditions.
// The synchronizers reset to 1 so an idle (pulled-up) bus produces no spurious events.
module i2c_bus_monitor (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sclRise_o,
  output logic sclFall_o,
  output logic sdaSync_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] sclSync_q;
  logic [1:0] sdaSync_q;
  logic       sclPrev_q;
  logic       sdaPrev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclSync_q <= 2'b11;
      sdaSync_q <= 2'b11;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[0], scl_i};
      sdaSync_q <= {sdaSync_q[0], sda_i};
      sclPrev_q <= sclSync_q[1];
      sdaPrev_q <= sdaSync_q[1];
    end
  end

  // START/STOP require SCL to have been high across the SDA transition.
  assign sclRise_o = sclSync_q[1] & ~sclPrev_q;
  assign sclFall_o = ~sclSync_q[1] & sclPrev_q;
  assign sdaSync_o = sdaSync_q[1];
  assign start_o   = sclSync_q[1] & sclPrev_q & sdaPrev_q & ~sdaSync_q[1];
  assign stop_o    = sclSync_q[1] & sclPrev_q & ~sdaPrev_q & sdaSync_q[1];

endmodule

// File: rtl/i2c_ina219_target.sv
// INA219-style I2C target: pointer register, writable config (reg 0) and read-only shunt/bus values.
// sda is open-drain; drive changes happen only on synchronized SCL falling edges.
module i2c_ina219_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h40,
  parameter logic [15:0] CONFIG_RST = 16'h399F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] shunt_v,
  input  logic [15:0] bus_v,
  output logic [15:0] config_out,
  output logic        busy,
  output logic        xfer_done
);

  logic sclRise, sclFall, sdaS, startCond, stopCond;

  i2c_bus_monitor uMonitor (
    .clk_i     (clk),
    .rst_ni    (reset),
    .scl_i     (scl),
    .sda_i     (sda),
    .sclRise_o (sclRise),
    .sclFall_o (sclFall),
    .sdaSync_o (sdaS),
    .start_o   (startCond),
    .stop_o    (stopCond)
  );

  i2c_state_e  state_q, state_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  i2c_ptr_t    ptr_q, ptr_d;
  logic [15:0] config_q, config_d;
  logic [15:0] snap_q, snap_d;
  logic [7:0]  wrMsb_q, wrMsb_d;
  logic        ackPhase_q, ackPhase_d;
  logic        lsbPhase_q, lsbPhase_d;
  logic        nack_q, nack_d;
  logic        sdaLow_q, sdaLow_d;
  logic        busy_q, busy_d;
  logic        xferDone_q, xferDone_d;

  logic [7:0] rxByte;
  logic [3:0] txIdx;

  assign rxByte = {shift_q, sdaS};
  assign txIdx  = {state_q == RD_MSB, bitCnt_q - 3'd1};

  // Reset releases sda asynchronously because sdaLow_q directly gates the pad.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= 3'd7;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= REG_CONFIG;
      config_q   <= CONFIG_RST;
      snap_q     <= '0;
      wrMsb_q    <= '0;
      ackPhase_q <= 1'b0;
      lsbPhase_q <= 1'b0;
      nack_q     <= 1'b1;
      sdaLow_q   <= 1'b0;
      busy_q     <= 1'b0;
      xferDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      config_q   <= config_d;
      snap_q     <= snap_d;
      wrMsb_q    <= wrMsb_d;
      ackPhase_q <= ackPhase_d;
      lsbPhase_q <= lsbPhase_d;
      nack_q     <= nack_d;
      sdaLow_q   <= sdaLow_d;
      busy_q     <= busy_d;
      xferDone_q <= xferDone_d;
    end
  end

  // Bits are sampled on SCL rise; ACK states drive on the first fall and exit on the second.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    config_d   = config_q;
    snap_d     = snap_q;
    wrMsb_d    = wrMsb_q;
    ackPhase_d = ackPhase_q;
    lsbPhase_d = lsbPhase_q;
    nack_d     = nack_q;
    sdaLow_d   = sdaLow_q;
    busy_d     = busy_q;
    xferDone_d = 1'b0;

    if (stopCond) begin
      state_d    = IDLE;
      sdaLow_d   = 1'b0;
      busy_d     = 1'b0;
      xferDone_d = busy_q;
    end else if (startCond) begin
      state_d  = ADDR;
      bitCnt_d = 3'd7;
      sdaLow_d = 1'b0;
    end else if (sclRise) begin
      case (state_q)
        ADDR, PTR, WR_MSB, WR_LSB: begin
          shift_d  = rxByte[6:0];
          bitCnt_d = bitCnt_q - 3'd1;
          if (bitCnt_q == 3'd0) begin
            ackPhase_d = 1'b0;
            case (state_q)
              ADDR: begin
                if (shift_q == DEV_ADDR) begin
                  state_d = ADDR_ACK;
                  rw_d    = sdaS;
                  busy_d  = 1'b1;
                end else begin
                  state_d = WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end
              PTR: begin
                ptr_d   = rxByte[1:0];
                state_d = PTR_ACK;
              end
              WR_MSB: begin
                wrMsb_d = rxByte;
                state_d = WR_MSB_ACK;
              end
              default: begin
                if (ptr_q == REG_CONFIG) config_d = {wrMsb_q, rxByte};
                state_d = WR_LSB_ACK;
              end
            endcase
          end
        end
        ADDR_ACK: begin
          ackPhase_d = 1'b1;
          if (rw_q) snap_d = regSelect(ptr_q, config_q, shunt_v, bus_v);
        end
        PTR_ACK, WR_MSB_ACK, WR_LSB_ACK: ackPhase_d = 1'b1;
        RD_MACK: begin
          ackPhase_d = 1'b1;
          nack_d     = sdaS;
        end
        default: ;
      endcase
    end else if (sclFall) begin
      case (state_q)
        ADDR_ACK, PTR_ACK, WR_MSB_ACK, WR_LSB_ACK: begin
          if (!ackPhase_q) begin
            sdaLow_d = 1'b1;
          end else begin
            sdaLow_d = 1'b0;
            bitCnt_d = 3'd7;
            case (state_q)
              ADDR_ACK: begin
                if (rw_q) begin
                  state_d    = RD_MSB;
                  sdaLow_d   = ~snap_q[15];
                  lsbPhase_d = 1'b0;
                end else begin
                  state_d = PTR;
                end
              end
              PTR_ACK:    state_d = WR_MSB;
              WR_MSB_ACK: state_d = WR_LSB;
              default:    state_d = WAIT_STOP;
            endcase
          end
        end
        RD_MSB, RD_LSB: begin
          if (bitCnt_q == 3'd0) begin
            state_d    = RD_MACK;
            sdaLow_d   = 1'b0;
            ackPhase_d = 1'b0;
          end else begin
            bitCnt_d = bitCnt_q - 3'd1;
            sdaLow_d = ~snap_q[txIdx];
          end
        end
        RD_MACK: begin
          if (ackPhase_q) begin
            if (!lsbPhase_q && !nack_q) begin
              state_d    = RD_LSB;
              bitCnt_d   = 3'd7;
              sdaLow_d   = ~snap_q[7];
              lsbPhase_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda        = sdaLow_q ? 1'b0 : 1'bz;
  assign config_out = config_q;
  assign busy       = busy_q;
  assign xfer_done  = xferDone_q;

endmodule
